// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, WB} mult_state_t;

  // Register-file address of the PC; results destined here are not written back.
  localparam logic [3:0] REG_PC = 4'hF;

  // Number of RUN cycles needed to retire all 32 multiplier bits.
  function automatic int n_iter(input int step);
    return 32 / step;
  endfunction

endpackage

// File: rtl/mult_step_add.sv
// One multiply-accumulate step: adds mcand * slice, shifted left by shift,
// into the running accumulator. Purely combinational, modulo 2^32.
module mult_step_add #(
  parameter int STEP_BITS = 2
) (
  input  logic [31:0]          accum,
  input  logic [31:0]          mcand,
  input  logic [4:0]           shift,
  input  logic [STEP_BITS-1:0] slice,
  output logic [31:0]          sum
);

  logic [31:0] partial;

  // Partial product for this slice, aligned to its bit position, then accumulated.
  always_comb begin
    partial = mcand * 32'(slice);
    sum     = accum + (partial << shift);
  end

endmodule

// File: rtl/mult_iter_unit.sv
// Iterative 32x32->32 multiplier (MUL/MLA) producing a register-file write request.
// STEP_BITS multiplier bits are retired per RUN cycle, LSB first.
// Optional feature macro: MULT_MLA_EN enables the accumulate (MLA) path; without
// it the acc/accumulate ports are ignored and the accumulator always starts at 0.
module mult_iter_unit
  import mult_pkg::*;
#(
  parameter int STEP_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] acc,
  input  logic        accumulate,
  input  logic [3:0]  rd_addr,
  input  logic        set_flags,
  output logic        busy,
  output logic        done,
  output logic        we3,
  output logic [3:0]  a3,
  output logic [31:0] wd3,
  output logic        n_flag,
  output logic        z_flag
);

  localparam int         N_ITER   = n_iter(STEP_BITS);
  localparam logic [5:0] LAST_CNT = 6'(N_ITER - 1);

  mult_state_t state_reg, state_next;
  logic        accept;
  logic [5:0]  cnt_reg;
  logic [31:0] mcand_reg;
  logic [31:0] mplier_reg;
  logic [31:0] acc_reg;
  logic [3:0]  rd_reg;
  logic        sf_reg;
  logic [31:0] step_sum;
  logic [4:0]  shift_amt;
  logic        last_iter;
  logic [31:0] acc_init;

`ifdef MULT_MLA_EN
  assign acc_init = accumulate ? acc : 32'h0;
`else
  // MUL-only build: accumulate operands are deliberately not consumed.
  logic unused_mla;
  assign unused_mla = ^{acc, accumulate};
  assign acc_init   = 32'h0;
`endif

  assign shift_amt = 5'(cnt_reg * 6'(STEP_BITS));
  assign last_iter = (cnt_reg == LAST_CNT);
  assign busy      = (state_reg != IDLE);

  mult_step_add #(.STEP_BITS(STEP_BITS)) u_step (
    .accum (acc_reg),
    .mcand (mcand_reg),
    .shift (shift_amt),
    .slice (mplier_reg[STEP_BITS-1:0]),
    .sum   (step_sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; a new op may be accepted in IDLE or on the edge ending WB.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_iter) state_next = WB;
      end
      WB: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latching, iteration datapath and registered write-back outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= 6'd0;
      mcand_reg  <= 32'h0;
      mplier_reg <= 32'h0;
      acc_reg    <= 32'h0;
      rd_reg     <= 4'h0;
      sf_reg     <= 1'b0;
      done       <= 1'b0;
      we3        <= 1'b0;
      a3         <= 4'h0;
      wd3        <= 32'h0;
      n_flag     <= 1'b0;
      z_flag     <= 1'b0;
    end else begin
      done <= 1'b0;
      we3  <= 1'b0;
      if (accept) begin
        mcand_reg  <= op_a;
        mplier_reg <= op_b;
        acc_reg    <= acc_init;
        rd_reg     <= rd_addr;
        sf_reg     <= set_flags;
        cnt_reg    <= 6'd0;
      end else if (state_reg == RUN) begin
        acc_reg    <= step_sum;
        mplier_reg <= mplier_reg >> STEP_BITS;
        cnt_reg    <= cnt_reg + 6'd1;
        if (last_iter) begin
          done <= 1'b1;
          we3  <= (rd_reg != REG_PC);
          a3   <= rd_reg;
          wd3  <= step_sum;
          if (sf_reg) begin
            n_flag <= step_sum[31];
            z_flag <= (step_sum == 32'h0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_iter_unit.sv
// Self-checking bench for mult_iter_unit (STEP_BITS=2, 16 iterations).
// Expected results come from plain 32-bit arithmetic on the issued operands.
module tb_mult_iter_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;
  logic [31:0] acc = 32'h0;
  logic        accumulate = 1'b0;
  logic [3:0]  rd_addr = 4'h0;
  logic        set_flags = 1'b0;
  logic        busy, done, we3, n_flag, z_flag;
  logic [3:0]  a3;
  logic [31:0] wd3;

  int compared = 0;
  int mismatched = 0;
  int we3_seen = 0;
  logic n_exp = 1'b0;
  logic z_exp = 1'b0;

  localparam int LATENCY = 17;

  mult_iter_unit #(.STEP_BITS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .acc(acc),
    .accumulate(accumulate), .rd_addr(rd_addr), .set_flags(set_flags),
    .busy(busy), .done(done), .we3(we3), .a3(a3), .wd3(wd3),
    .n_flag(n_flag), .z_flag(z_flag)
  );

  always #5 clk = ~clk;

  // Counts every clock cycle during which a write request was presented.
  always @(posedge clk) if (we3 === 1'b1) we3_seen++;

  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic accum);
`ifdef MULT_MLA_EN
    return (accum ? c : 32'h0) + a * b;
`else
    return a * b;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents an op for one edge (caller is just after a posedge), then scrambles inputs.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic accum, input logic [3:0] rd, input logic sf);
    op_a = a; op_b = b; acc = c; accumulate = accum; rd_addr = rd; set_flags = sf;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; acc = $urandom;
    accumulate = 1'($urandom); rd_addr = 4'($urandom); set_flags = 1'($urandom);
  endtask

  // Waits (bounded) for done at negedges; returns cycles since acceptance or -1.
  task automatic wait_done(output int lat, output logic busy_first);
    lat = -1;
    busy_first = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) busy_first = busy;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Full transaction: issue, check WB outputs and latency, then the idle cycle after.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic accum, input logic [3:0] rd,
                        input logic sf);
    int lat;
    logic bf;
    logic [31:0] exp;
    int w0;
    exp = ref_result(a, b, c, accum);
    w0 = we3_seen;
    issue(a, b, c, accum, rd, sf);
    wait_done(lat, bf);
    if (sf) begin
      n_exp = exp[31];
      z_exp = (exp == 32'h0);
    end
    check({name, ".busy_run"}, 32'(bf), 32'd1);
    check({name, ".latency"}, 32'(lat), 32'(LATENCY));
    check({name, ".we3"}, 32'(we3), 32'(rd != 4'hF));
    check({name, ".a3"}, 32'(a3), 32'(rd));
    check({name, ".wd3"}, wd3, exp);
    check({name, ".n_flag"}, 32'(n_flag), 32'(n_exp));
    check({name, ".z_flag"}, 32'(z_flag), 32'(z_exp));
    @(posedge clk); #1;
    check({name, ".busy_after"}, 32'(busy), 32'd0);
    check({name, ".done_after"}, 32'(done), 32'd0);
    check({name, ".writes"}, 32'(we3_seen - w0), 32'(rd != 4'hF));
    $display("op %s: a=%h b=%h acc=%h mla=%0b rd=%0d s=%0b -> wd3=%h lat=%0d n=%0b z=%0b",
             name, a, b, c, accum, rd, sf, wd3, lat, n_flag, z_flag);
  endtask

  initial begin
    int lat;
    logic bf;
    int w0;
    logic [31:0] exp1, exp2;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.we3", 32'(we3), 32'd0);
    check("reset.a3", 32'(a3), 32'h0);
    check("reset.wd3", wd3, 32'h0);
    check("reset.nz", 32'({n_flag, z_flag}), 32'd0);
    $display("reset: busy=%0b done=%0b we3=%0b a3=%h wd3=%h", busy, done, we3, a3, wd3);

    // Directed cases
    run_op("mul7x6", 32'd7, 32'd6, 32'd0, 1'b0, 4'd3, 1'b0);
    run_op("mla_wrap", 32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 4'd4, 1'b1);
    run_op("mul_ovf", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 4'd5, 1'b1);
    run_op("mul_pc", 32'd3, 32'd3, 32'd0, 1'b0, 4'hF, 1'b0);

    // start re-asserted through every RUN cycle: only one write must result
    w0 = we3_seen;
    op_a = 32'd11; op_b = 32'd13; acc = 32'd0; accumulate = 1'b0; rd_addr = 4'd6; set_flags = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    op_a = 32'd99; op_b = 32'd99;
    repeat (16) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(negedge clk);
    check("hold_run.done", 32'(done), 32'd1);
    check("hold_run.wd3", wd3, 32'd143);
    repeat (20) @(posedge clk);
    #1;
    check("hold_run.writes", 32'(we3_seen - w0), 32'd1);
    check("hold_run.busy", 32'(busy), 32'd0);
    $display("op hold_run: wd3=%h writes=%0d", wd3, we3_seen - w0);

    // start presented during WB: accepted back-to-back, busy stays high
    w0 = we3_seen;
    exp1 = ref_result(32'h1234_5678, 32'h9ABC_DEF1, 32'd0, 1'b0);
    exp2 = ref_result(32'hCAFE_0001, 32'h0000_0F0F, 32'd0, 1'b0);
    issue(32'h1234_5678, 32'h9ABC_DEF1, 32'd0, 1'b0, 4'd7, 1'b0);
    wait_done(lat, bf);
    check("b2b.first_latency", 32'(lat), 32'(LATENCY));
    check("b2b.first_wd3", wd3, exp1);
    op_a = 32'hCAFE_0001; op_b = 32'h0000_0F0F; acc = 32'd0; accumulate = 1'b0;
    rd_addr = 4'd8; set_flags = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b.busy_kept", 32'(busy), 32'd1);
    check("b2b.done_cleared", 32'(done), 32'd0);
    wait_done(lat, bf);
    check("b2b.second_latency", 32'(lat), 32'(LATENCY));
    check("b2b.second_a3", 32'(a3), 32'd8);
    check("b2b.second_wd3", wd3, exp2);
    @(posedge clk); #1;
    check("b2b.writes", 32'(we3_seen - w0), 32'd2);
    $display("op b2b: first=%h second=%h writes=%0d", exp1, wd3, we3_seen - w0);

    // Reset mid-RUN aborts the operation
    w0 = we3_seen;
    issue(32'd5, 32'd9, 32'd0, 1'b0, 4'd2, 1'b1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_exp = 1'b0;
    z_exp = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.we3", 32'(we3), 32'd0);
    check("abort.a3", 32'(a3), 32'h0);
    check("abort.wd3", wd3, 32'h0);
    check("abort.nz", 32'({n_flag, z_flag}), 32'd0);
    repeat (25) @(posedge clk);
    #1;
    check("abort.writes", 32'(we3_seen - w0), 32'd0);
    check("abort.still_idle", 32'(busy | done), 32'd0);
    $display("op abort: busy=%0b we3 writes=%0d", busy, we3_seen - w0);

    // Randomised operations
    for (int k = 0; k < 12; k++) begin
      run_op($sformatf("rnd%0d", k), $urandom, $urandom, $urandom, 1'($urandom),
             4'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
